switch_edge_debounce: RTL and testbench

SWITCH_EDGE_DEBOUNCE -- requirements
Module: switch_edge_debounce

---
 rtl/switch_edge_debounce.sv | 145 ++++++++++++++
 tb/tb_switch_edge_debounce.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/switch_edge_debounce.sv
// Per-channel switch debouncer with 2-flop synchroniser and edge-qualified output pulses.
// Optional auto-repeat on held-high channels when SWITCH_REPEAT_EN is defined.
module switch_edge_debounce #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_MODE       = 0,
    parameter int REPEAT_CYCLES   = 25000000
) (
    input  logic             CLK50MHZ,
    input  logic             RST,
    input  logic [WIDTH-1:0] sw_in,
    output logic [WIDTH-1:0] sw_out,
    output logic [WIDTH-1:0] sw_level
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

    if (WIDTH < 1 || WIDTH > 32 || DEBOUNCE_CYCLES < 1 || EDGE_MODE < 0 || EDGE_MODE > 2 ||
        REPEAT_CYCLES < 1) begin : g_bad_param
        $error("switch_edge_debounce: illegal parameter value");
    end

    typedef enum logic {
        ST_STABLE,
        ST_SETTLING
    } state_t;

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_level;
    logic [WIDTH-1:0] r_out;
    state_t           r_state     [WIDTH];
    state_t           w_state_nxt [WIDTH];
    logic [CW-1:0]    r_cnt       [WIDTH];
    logic [CW-1:0]    w_cnt_nxt   [WIDTH];
    logic [WIDTH-1:0] w_level_nxt;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_rep;

    always_ff @(posedge CLK50MHZ) begin
        if (RST) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_level <= '0;
            r_out   <= '0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                r_state[i] <= ST_STABLE;
                r_cnt[i]   <= '0;
            end
        end else begin
            r_sync1 <= sw_in;
            r_sync2 <= r_sync1;
            r_level <= w_level_nxt;
            r_out   <= w_edge | w_rep;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_cnt[i]   <= w_cnt_nxt[i];
            end
        end
    end

    always_comb begin
        w_level_nxt = r_level;
        w_edge      = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            w_state_nxt[i] = r_state[i];
            w_cnt_nxt[i]   = r_cnt[i];
            case (r_state[i])
                ST_STABLE: begin
                    if (r_sync2[i] != r_level[i]) begin
                        w_state_nxt[i] = ST_SETTLING;
                        w_cnt_nxt[i]   = CW'(1);
                    end else begin
                        w_cnt_nxt[i] = '0;
                    end
                end
                ST_SETTLING: begin
                    if (r_sync2[i] == r_level[i]) begin
                        w_state_nxt[i] = ST_STABLE;
                        w_cnt_nxt[i]   = '0;
                    end else if (r_cnt[i] == CNT_MAX) begin
                        w_state_nxt[i] = ST_STABLE;
                        w_cnt_nxt[i]   = '0;
                        w_level_nxt[i] = ~r_level[i];
                        // r_level[i] is the old level: 0 means this is a rising change
                        w_edge[i] = (EDGE_MODE == 2) ||
                                    (EDGE_MODE == 0 && !r_level[i]) ||
                                    (EDGE_MODE == 1 && r_level[i]);
                    end else begin
                        w_cnt_nxt[i] = r_cnt[i] + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt[i] = ST_STABLE;
                    w_cnt_nxt[i]   = '0;
                end
            endcase
        end
    end

`ifdef SWITCH_REPEAT_EN
    localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [RW-1:0] REP_MAX = RW'(REPEAT_CYCLES - 1);

    logic [RW-1:0] r_rcnt     [WIDTH];
    logic [RW-1:0] w_rcnt_nxt [WIDTH];

    always_ff @(posedge CLK50MHZ) begin
        if (RST) begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                r_rcnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                r_rcnt[i] <= w_rcnt_nxt[i];
            end
        end
    end

    // Repeat counter pauses while a held-high channel is settling, clears once the level is low
    always_comb begin
        w_rep = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            w_rcnt_nxt[i] = r_rcnt[i];
            if (!r_level[i]) begin
                w_rcnt_nxt[i] = '0;
            end else if (r_state[i] == ST_STABLE) begin
                if (r_rcnt[i] == REP_MAX) begin
                    w_rcnt_nxt[i] = '0;
                    w_rep[i]      = (EDGE_MODE != 1);
                end else begin
                    w_rcnt_nxt[i] = r_rcnt[i] + 1'b1;
                end
            end
        end
    end
`else
    assign w_rep = '0;
`endif

    assign sw_out   = r_out;
    assign sw_level = r_level;

endmodule

// File: tb/tb_switch_edge_debounce.sv
// Randomised self-checking bench: three DUTs (edge modes 0/1/2) against a run-length reference model.
module tb_switch_edge_debounce;

    localparam int W = 4;
    localparam int D = 4;
    localparam int R = 8;

    logic         clk = 1'b0;
    logic         RST;
    logic [W-1:0] sw_in;
    logic [W-1:0] w_out [3];
    logic [W-1:0] w_lvl [3];

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    always #10 clk = ~clk;

    switch_edge_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_MODE(0), .REPEAT_CYCLES(R)) u_dut0 (
        .CLK50MHZ(clk), .RST(RST), .sw_in(sw_in), .sw_out(w_out[0]), .sw_level(w_lvl[0]));
    switch_edge_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_MODE(1), .REPEAT_CYCLES(R)) u_dut1 (
        .CLK50MHZ(clk), .RST(RST), .sw_in(sw_in), .sw_out(w_out[1]), .sw_level(w_lvl[1]));
    switch_edge_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_MODE(2), .REPEAT_CYCLES(R)) u_dut2 (
        .CLK50MHZ(clk), .RST(RST), .sw_in(sw_in), .sw_out(w_out[2]), .sw_level(w_lvl[2]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    // Reference model: a level is accepted once the synchronised input has disagreed
    // with it for D+1 consecutive samples; pulses follow the accepted changes.
    logic [W-1:0] m_s1, m_s2, m_lvl, old_lvl;
    logic [W-1:0] m_out [3];
    int           m_run [W];
    int           m_rep [W];
    bit           stable_before;

    always @(posedge clk) begin
        if (RST) begin
            m_s1 = '0;
            m_s2 = '0;
            m_lvl = '0;
            for (int m = 0; m < 3; m++) m_out[m] = '0;
            for (int i = 0; i < W; i++) begin
                m_run[i] = 0;
                m_rep[i] = 0;
            end
        end else begin
            old_lvl = m_lvl;
            for (int m = 0; m < 3; m++) m_out[m] = '0;
            for (int i = 0; i < W; i++) begin
                stable_before = (m_run[i] == 0);
                if (m_s2[i] != m_lvl[i]) begin
                    m_run[i]++;
                    if (m_run[i] == D + 1) begin
                        m_lvl[i] = ~m_lvl[i];
                        m_run[i] = 0;
                        if (m_lvl[i]) m_out[0][i] = 1'b1;
                        else          m_out[1][i] = 1'b1;
                        m_out[2][i] = 1'b1;
                    end
                end else begin
                    m_run[i] = 0;
                end
`ifdef SWITCH_REPEAT_EN
                if (!old_lvl[i]) m_rep[i] = 0;
                else if (stable_before) begin
                    m_rep[i]++;
                    if (m_rep[i] == R) begin
                        m_rep[i] = 0;
                        m_out[0][i] = 1'b1;
                        m_out[2][i] = 1'b1;
                    end
                end
`endif
            end
            m_s2 = m_s1;
            m_s1 = sw_in;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int m = 0; m < 3; m++) begin
                check($sformatf("out_mode%0d", m), 32'(w_out[m]), 32'(m_out[m]));
                check($sformatf("level_mode%0d", m), 32'(w_lvl[m]), 32'(m_lvl));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Counts cycles over a window in which the given DUT's output equals the pattern
    task automatic count_out(input int n, input int mode, input logic [W-1:0] pat, output int cnt);
        cnt = 0;
        repeat (n) begin
            @(negedge clk);
            if (w_out[mode] == pat) cnt++;
        end
    endtask

    int pc;
    int p;

    initial begin
        RST   = 1'b1;
        sw_in = '0;
        tick(3);
        chk_en = 1'b1;
        tick(1);
        check("reset_level", 32'(w_lvl[0]), 32'h0);
        check("reset_out", 32'(w_out[2]), 32'h0);
        RST = 1'b0;
        tick(2);

        // single rising change on channel 0
        sw_in = 4'b0001;
        count_out(12, 0, 4'b0001, pc);
        check("ch0_single_pulse", 32'(pc), 32'd1);
        sw_in = '0;
        tick(12);

        // bouncing channel 1 settles to one pulse
        sw_in = 4'b0010; tick(1);
        sw_in = 4'b0000; tick(1);
        sw_in = 4'b0010; tick(1);
        sw_in = 4'b0000; tick(1);
        sw_in = 4'b0010;
        count_out(14, 0, 4'b0010, pc);
        check("ch1_bounce_pulse", 32'(pc), 32'd1);
        sw_in = '0;
        tick(12);

        // all channels together, both directions
        sw_in = 4'hF;
        tick(20);
        sw_in = 4'h0;
        count_out(20, 1, 4'hF, pc);
        check("all_fall_pulse", 32'(pc), 32'd1);

        // reset in the middle of settling on channel 2
        sw_in = 4'b0100;
        tick(4);
        RST = 1'b1;
        tick(2);
        RST = 1'b0;
        tick(12);
        sw_in = '0;
        tick(12);

        // channel 3 held high: initial pulse plus optional repeats
        sw_in = 4'b1000;
        count_out(40, 0, 4'b1000, pc);
`ifdef SWITCH_REPEAT_EN
        check("ch3_held_pulses", 32'(pc), 32'd5);
`else
        check("ch3_held_pulses", 32'(pc), 32'd1);
`endif
        sw_in = '0;
        tick(12);

        // random segments with varying bounce density and occasional reset
        for (int seg = 0; seg < 30; seg++) begin
            p = $urandom_range(0, 3);
            for (int c = 0; c < 50; c++) begin
                @(negedge clk);
                for (int i = 0; i < W; i++)
                    if ($urandom_range(0, (1 << (2 * p + 1)) - 1) == 0) sw_in[i] = ~sw_in[i];
                RST = ($urandom_range(0, 199) == 0);
            end
        end
        RST = 1'b0;
        tick(20);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
